mmio_uart_tx: RTL and testbench

Byte-serial UART transmitter that consumes one MemoryMappedIO output port and reports status on one MemoryMappedIO input port. Software writes a byte and a toggle flag to its port. The block detects each new request, queues the byte in a small FIFO and shifts it out as 8N1 on `txd`. It sits directly downstream of the MMIO write registers and upstream of the MMIO read mux.

---
 rtl/mmio_uart_tx_pkg.sv | 39 +++
 rtl/mmio_uart_tx_if.sv | 12 +
 rtl/mmio_uart_tx_fifo.sv | 54 +++++
 rtl/mmio_uart_tx.sv | 143 ++++++++++++++
 tb/tb_mmio_uart_tx.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and constants for the MMIO UART transmitter: the FSM state
// type and the bit positions of the status word, so software and tests can
// decode statusPort without hard-coding numbers.
package mmio_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } UartTxState_t;

    // Status word layout
    localparam int STATUS_ACK_BIT   = 0;
    localparam int STATUS_BUSY_BIT  = 1;
    localparam int STATUS_FULL_BIT  = 2;
    localparam int STATUS_COUNT_LSB = 4;
    localparam int STATUS_COUNT_MSB = 7;

    // Width of the FIFO occupancy count (holds 0..8)
    localparam int COUNT_W = 4;

    // Assemble the 32-bit status word; every bit not listed is zero.
    function automatic logic [31:0] pack_status(
        input logic               ack,
        input logic               busy,
        input logic               full,
        input logic [COUNT_W-1:0] count
    );
        logic [31:0] s;
        s = '0;
        s[STATUS_ACK_BIT]                     = ack;
        s[STATUS_BUSY_BIT]                    = busy;
        s[STATUS_FULL_BIT]                    = full;
        s[STATUS_COUNT_MSB:STATUS_COUNT_LSB]  = count;
        return s;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// MMIO port pair between the processor's MMIO registers and the UART.
// Handshake: software flips txPort[8] to present a new byte in txPort[7:0];
// the request counts as accepted on the clock edge where statusPort[0]
// (ack) becomes equal to txPort[8]. Until then the request stays pending
// and txPort must be held stable.
interface mmio_uart_tx_if;
    logic [31:0] txPort;
    logic [31:0] statusPort;

    modport master (output txPort, input  statusPort);
    modport slave  (input  txPort, output statusPort);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Byte FIFO: circular buffer with wrapping pointers and an occupancy count.
// Push when full and pop when empty are ignored.
module mmio_uart_tx_fifo
    import mmio_uart_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push_i,
    input  logic [7:0]         data_i,
    input  logic               pop_i,
    output logic [7:0]         data_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [COUNT_W-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]         mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      rd_ptr_q;
    logic [COUNT_W-1:0] count_q;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count_q == COUNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count nets push and pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + COUNT_W'(do_push) - COUNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: detects toggle-flagged byte requests on txPort,
// queues them in a small FIFO and shifts each out as 8N1 on txd, LSB first.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 434,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                clock,
    input  logic                reset,
    mmio_uart_tx_if.slave       bus,
    output logic                txd,
    output UartTxState_t        dbg_state_o
);
    localparam int                BAUD_W    = $clog2(CLOCKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);

    UartTxState_t       state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [7:0]         shift_q, shift_d;
    logic [2:0]         bit_q, bit_d;
    logic               last_tog_q;

    logic               pending;
    logic               fifo_push;
    logic               fifo_pop;
    logic [7:0]         fifo_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic [COUNT_W-1:0] fifo_count;
    logic               bit_done;
    logic               busy;
    logic               unused_tx_bits;

    // Upper txPort bits carry nothing for this block.
    assign unused_tx_bits = ^bus.txPort[31:9];

    // A request is pending while the toggle differs from the last accepted one;
    // it is accepted only if the FIFO had room before this edge.
    assign pending   = (bus.txPort[8] != last_tog_q);
    assign fifo_push = pending && !fifo_full;
    assign bit_done  = (baud_q == BAUD_LAST);

    mmio_uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (fifo_push),
        .data_i  (bus.txPort[7:0]),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Toggle tracker: records the toggle of the last accepted request (the ack).
    always_ff @(posedge clock) begin
        if (reset) begin
            last_tog_q <= 1'b0;
        end else if (fifo_push) begin
            last_tog_q <= bus.txPort[8];
        end
    end

    // FSM, baud counter, shifter and bit index registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            shift_q <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
        end
    end

    // Next-state logic: one bit time per state/bit, advancing on the last baud count.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_data;
                    baud_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level decoded from registered state only.
    always_comb begin
        txd = 1'b1;
        case (state_q)
            START:   txd = 1'b0;
            DATA:    txd = shift_q[0];
            default: txd = 1'b1;
        endcase
    end

    assign busy           = (state_q != IDLE) || (fifo_count != '0);
    assign bus.statusPort = pack_status(last_tog_q, busy, fifo_full, fifo_count);
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios with random bytes, checked every
// cycle against a frame-schedule model plus a line-level UART receiver.
module tb_mmio_uart_tx;
    import mmio_uart_tx_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    // ---------------- clock / reset / DUT ----------------
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  tx_port = '0;
    logic         txd;
    UartTxState_t dbg_state;

    mmio_uart_tx_if bus ();
    assign bus.txPort = tx_port;

    mmio_uart_tx #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .txd         (txd),
        .dbg_state_o (dbg_state)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- counters ----------------
    int n_checks = 0;
    int n_passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    // Bytes waiting in the FIFO, last accepted toggle, and the edge index at
    // which the current/most recent frame's start bit began.
    logic [7:0] fifo_m [$];
    logic       last_tog_m = 1'b0;
    int         fp = -1000;
    logic [7:0] frame_byte = '0;
    int         n = 0;
    logic       cur_tog = 1'b0;

    // Scoreboard of accepted bytes and detected start edges.
    logic [7:0] exp_q [$];
    int         starts_q [$];

    logic       rx_busy = 1'b0;
    int         rx_start = 0;
    logic [7:0] rx_byte = '0;
    logic       prev_txd = 1'b1;

    function automatic logic frame_active();
        return (n >= fp) && (n < fp + FRAME);
    endfunction

    function automatic logic exp_txd();
        int idx;
        if (!frame_active()) return 1'b1;
        idx = (n - fp) / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return frame_byte[idx-1];
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        logic        busy;
        busy = (fifo_m.size() != 0) || frame_active();
        s = '0;
        s[0]   = last_tog_m;
        s[1]   = busy;
        s[2]   = (fifo_m.size() == DEPTH);
        s[7:4] = 4'(fifo_m.size());
        return s;
    endfunction

    // Apply the block's rules for one rising edge using the inputs held there.
    task automatic model_edge();
        int cnt_before;
        if (reset) begin
            fifo_m.delete();
            last_tog_m = 1'b0;
            fp = -1000;
            return;
        end
        cnt_before = fifo_m.size();
        // A new frame may start only after the previous frame plus one idle clock.
        if (cnt_before > 0 && n >= fp + FRAME + 1) begin
            frame_byte = fifo_m.pop_front();
            fp = n;
        end
        if (tx_port[8] != last_tog_m && cnt_before < DEPTH) begin
            fifo_m.push_back(tx_port[7:0]);
            exp_q.push_back(tx_port[7:0]);
            last_tog_m = tx_port[8];
        end
    endtask

    // Line-level receiver: finds start bits and samples mid-bit.
    task automatic rx_update();
        int k;
        if (reset) begin
            rx_busy = 1'b0;
            exp_q.delete();
        end else if (!rx_busy && prev_txd && !txd) begin
            rx_busy  = 1'b1;
            rx_start = n;
            rx_byte  = '0;
            starts_q.push_back(n);
        end else if (rx_busy) begin
            k = n - rx_start;
            if ((k % CPB) == CPB / 2 && k / CPB >= 1 && k / CPB <= 8)
                rx_byte[k/CPB-1] = txd;
            if (k == 9 * CPB + CPB / 2) begin
                check("rx_stop", {31'b0, txd}, 32'd1);
                check("rx_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("rx_byte", {24'b0, rx_byte}, {24'b0, exp_q.pop_front()});
                rx_busy = 1'b0;
            end
        end
        prev_txd = txd;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
        n++;
        model_edge();
        check("status", bus.statusPort, exp_status());
        check("txd", {31'b0, txd}, {31'b0, exp_txd()});
        rx_update();
    endtask

    task automatic send(input logic [7:0] b);
        cur_tog = ~cur_tog;
        tx_port = {23'b0, cur_tog, b};
        for (int k = 0; k < 400 && bus.statusPort[0] !== cur_tog; k++) step();
        check("ack", {31'b0, bus.statusPort[0]}, {31'b0, cur_tog});
    endtask

    task automatic drain();
        for (int k = 0; k < 3000 && bus.statusPort[1] !== 1'b0; k++) step();
        check("drain_idle", {31'b0, bus.statusPort[1]}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int k;
        int nst;

        // Reset held for two edges
        reset = 1'b1;
        tx_port = '0;
        step();
        step();
        check("rst_txd", {31'b0, txd}, 32'd1);
        check("rst_status", bus.statusPort, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
        repeat (3) step();

        // Single byte 0xA5
        nst = starts_q.size();
        cur_tog = 1'b1;
        tx_port = 32'h0000_01A5;
        step();
        check("s2_ack", {31'b0, bus.statusPort[0]}, 32'd1);
        step();
        check("s2_start_low", {31'b0, txd}, 32'd0);
        k = 2;
        while (bus.statusPort[1] !== 1'b0 && k < 200) begin
            step();
            k++;
        end
        check("s2_busy_clear", k, 32'd42);
        check("s2_frames", starts_q.size() - nst, 32'd1);

        // Byte change without a toggle flip sends nothing
        nst = starts_q.size();
        tx_port = {23'b0, cur_tog, 8'h3C};
        repeat (50) step();
        check("s3_count", {28'b0, bus.statusPort[7:4]}, 32'd0);
        check("s3_no_frame", starts_q.size(), nst);

        // Overflow: five accepted at once, sixth waits for the next pop
        nst = starts_q.size();
        for (int i = 0; i < 5; i++) send(8'($urandom_range(0, 255)));
        check("s4_full", {31'b0, bus.statusPort[2]}, 32'd1);
        check("s4_count", {28'b0, bus.statusPort[7:4]}, 32'd4);
        send(8'($urandom_range(0, 255)));
        check("s4_ack6_edge", n, starts_q[nst] + FRAME + 2);
        drain();
        check("s4_frames", starts_q.size() - nst, 32'd6);

        // Back-to-back 0x00 then 0xFF
        repeat (5) step();
        nst = starts_q.size();
        send(8'h00);
        send(8'hFF);
        drain();
        check("s5_frames", starts_q.size() - nst, 32'd2);
        if (starts_q.size() >= nst + 2)
            check("s5_gap", starts_q[nst+1] - starts_q[nst], 32'd41);

        // Random traffic with random gaps
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 50)) step();
            send(8'($urandom_range(0, 255)));
        end
        drain();
        check("rand_all_received", exp_q.size(), 32'd0);

        // Reset during data bit 3 with two bytes queued
        repeat (3) step();
        nst = starts_q.size();
        for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)));
        for (k = 0; k < 200 && (starts_q.size() <= nst || n < starts_q[nst] + 4 * CPB + 2); k++) step();
        check("s6_mid_frame", {30'b0, 2'(dbg_state)}, 32'(DATA));
        reset = 1'b1;
        tx_port = '0;
        cur_tog = 1'b0;
        step();
        check("s6_rst_txd", {31'b0, txd}, 32'd1);
        check("s6_rst_status", bus.statusPort, 32'h0);
        reset = 1'b0;
        repeat (60) step();
        check("s6_no_frames", starts_q.size(), nst + 1);
        check("s6_idle_status", bus.statusPort, 32'h0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
